// File: rtl/keypad_code_lock.sv
// -----------------------------------------------------------------------------
// keypad_code_lock
//
// Digit-entry code lock fed by a matrix keypad scanner. Each key_valid pulse
// delivers one decoded key. Decimal digits shift into an entry register. A
// compares the entry with the stored code and drives the unlocked, err and
// lockout status outputs. C clears the entry. D/E/F are always ignored.
// One down-counter is shared by the timed states FAIL, UNLOCKED and LOCKOUT.
//
// Optional feature (compile-time macro KEYPAD_CODE_CHANGE_EN):
//   When defined, B while unlocked enters NEWCODE. A full-length entry
//   confirmed with A then replaces the stored code. When undefined, the code
//   is the constant INIT_CODE and B is ignored.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_valid  in   one-cycle strobe: key_code is a new press
//   key_code   in   [3:0] 0-9 digit, A enter, B change code, C clear
//   entry_val  out  [4*CODE_LEN-1:0] digits entered so far, right-aligned BCD
//   digit_cnt  out  [3:0] number of digits in entry_val
//   unlocked   out  high in UNLOCKED (and NEWCODE)
//   err        out  high in FAIL
//   lockout    out  high in LOCKOUT
// -----------------------------------------------------------------------------
module keypad_code_lock #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] INIT_CODE      = 16'h1234,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    ERR_CYCLES     = 50_000_000,
  parameter int                    UNLOCK_CYCLES  = 250_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [4*CODE_LEN-1:0]   entry_val,
  output logic [3:0]              digit_cnt,
  output logic                    unlocked,
  output logic                    err,
  output logic                    lockout
);

  localparam int EW    = 4 * CODE_LEN;
  localparam int T_AB  = (ERR_CYCLES > UNLOCK_CYCLES) ? ERR_CYCLES : UNLOCK_CYCLES;
  localparam int T_MAX = (T_AB > LOCKOUT_CYCLES) ? T_AB : LOCKOUT_CYCLES;
  // Timer counts from N-1 down to 0, so it only has to hold T_MAX-1.
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int FW    = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] ERR_LOAD     = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    LEN4         = 4'(CODE_LEN);
  localparam logic [FW-1:0] MAXF         = FW'(MAX_FAIL);
  localparam logic [FW-1:0] MAXF_M1      = FW'(MAX_FAIL - 1);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_FAIL,
    S_UNLOCKED,
    S_LOCKOUT,
    S_NEWCODE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            unlocked_q, unlocked_d;
  logic            err_q, err_d;
  logic            lockout_q, lockout_d;
  logic [EW-1:0]   code_cur;
  logic [EW-1:0]   shifted;

  logic is_digit, is_enter, is_clear, timer_exp;

  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_enter  = key_valid && (key_code == 4'hA);
  assign is_clear  = key_valid && (key_code == 4'hC);
  assign timer_exp = (timer_q == '0);

  // Entry with the new digit appended on the right; a one-digit code has
  // nothing to shift.
  generate
    if (CODE_LEN == 1) begin : g_shift_one
      assign shifted = key_code;
    end else begin : g_shift_many
      assign shifted = {entry_q[EW-5:0], key_code};
    end
  endgenerate

`ifdef KEYPAD_CODE_CHANGE_EN
  logic [EW-1:0] code_q, code_d;
  logic          is_change;
  assign is_change = key_valid && (key_code == 4'hB);
  assign code_cur  = code_q;
`else
  assign code_cur  = INIT_CODE;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
`ifdef KEYPAD_CODE_CHANGE_EN
    code_d  = code_q;
`endif

    case (state_q)
      S_LOCKED: begin
        if (is_digit) begin
          // A full entry ignores further digits rather than scrolling.
          if (cnt_q != LEN4) begin
            entry_d = shifted;
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (is_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (is_enter) begin
          entry_d = '0;
          cnt_d   = '0;
          if ((cnt_q == LEN4) && (entry_q == code_cur)) begin
            state_d = S_UNLOCKED;
            timer_d = UNLOCK_LOAD;
            fail_d  = '0;
          end else if (fail_q == MAXF_M1) begin
            state_d = S_LOCKOUT;
            timer_d = LOCKOUT_LOAD;
            fail_d  = MAXF;
          end else begin
            state_d = S_FAIL;
            timer_d = ERR_LOAD;
            fail_d  = fail_q + FW'(1);
          end
        end
      end

      S_FAIL: begin
        if (timer_exp) state_d = S_LOCKED;
        else           timer_d = timer_q - TW'(1);
      end

      S_UNLOCKED: begin
        // Expiry takes priority: a key arriving on the last cycle is dropped.
        if (timer_exp) begin
          state_d = S_LOCKED;
        end else begin
          timer_d = timer_q - TW'(1);
          if (is_clear) begin
            state_d = S_LOCKED;
`ifdef KEYPAD_CODE_CHANGE_EN
          end else if (is_change) begin
            state_d = S_NEWCODE;
            entry_d = '0;
            cnt_d   = '0;
`endif
          end
        end
      end

      S_LOCKOUT: begin
        if (timer_exp) begin
          state_d = S_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

`ifdef KEYPAD_CODE_CHANGE_EN
      S_NEWCODE: begin
        if (is_digit) begin
          if (cnt_q != LEN4) begin
            entry_d = shifted;
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (is_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (is_enter) begin
          // A short entry is discarded and the old code stays in force.
          if (cnt_q == LEN4) code_d = entry_q;
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_LOCKED;
        end
      end
`endif

      default: state_d = S_LOCKED;
    endcase

    unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_NEWCODE);
    err_d      = (state_d == S_FAIL);
    lockout_d  = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOCKED;
      timer_q    <= '0;
      entry_q    <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      err_q      <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      err_q      <= err_d;
      lockout_q  <= lockout_d;
    end
  end

`ifdef KEYPAD_CODE_CHANGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_q <= INIT_CODE;
    else        code_q <= code_d;
  end
`endif

  assign entry_val = entry_q;
  assign digit_cnt = cnt_q;
  assign unlocked  = unlocked_q;
  assign err       = err_q;
  assign lockout   = lockout_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// -----------------------------------------------------------------------------
// tb_keypad_code_lock
//
// Scoreboard bench for keypad_code_lock with short timers (ERR=5, UNLOCK=20,
// LOCKOUT=40). Every driven cycle pushes the hand-derived expected outputs
// for the following sample point; the sample after the clock edge pops and
// compares them. Covers unlock, wrong code, lockout, entry saturation, clear,
// ignored keys, early re-lock, expiry/key collision and (with
// KEYPAD_CODE_CHANGE_EN) code change plus reset restoring the initial code.
// -----------------------------------------------------------------------------
module tb_keypad_code_lock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_val;
  logic [3:0]  digit_cnt;
  logic        unlocked;
  logic        err;
  logic        lockout;

  always #5 clk = ~clk;

  keypad_code_lock #(
    .CODE_LEN       (4),
    .INIT_CODE      (16'h1234),
    .MAX_FAIL       (3),
    .ERR_CYCLES     (5),
    .UNLOCK_CYCLES  (20),
    .LOCKOUT_CYCLES (40)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry_val (entry_val),
    .digit_cnt (digit_cnt),
    .unlocked  (unlocked),
    .err       (err),
    .lockout   (lockout)
  );

  typedef struct {
    string       tag;
    logic [15:0] entry;
    logic [3:0]  cnt;
    logic        u;
    logic        e;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] e_entry, input logic [3:0] e_cnt,
                          input logic e_u, input logic e_e, input logic e_l);
    exp_t x;
    x.tag   = tag;
    x.entry = e_entry;
    x.cnt   = e_cnt;
    x.u     = e_u;
    x.e     = e_e;
    x.l     = e_l;
    exp_q.push_back(x);
  endtask

  task automatic compare_outputs();
    exp_t x;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    x = exp_q.pop_front();
    check($sformatf("%s.entry", x.tag),    32'(entry_val), 32'(x.entry));
    check($sformatf("%s.cnt", x.tag),      32'(digit_cnt), 32'(x.cnt));
    check($sformatf("%s.unlocked", x.tag), 32'(unlocked),  32'(x.u));
    check($sformatf("%s.err", x.tag),      32'(err),       32'(x.e));
    check($sformatf("%s.lockout", x.tag),  32'(lockout),   32'(x.l));
  endtask

  // One clock cycle: drive (v,k), then sample just after the edge.
  task automatic tick(input logic v, input logic [3:0] k, input string tag,
                      input logic [15:0] e_entry, input logic [3:0] e_cnt,
                      input logic e_u, input logic e_e, input logic e_l);
    push_exp(tag, e_entry, e_cnt, e_u, e_e, e_l);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    compare_outputs();
    if (v)
      $display("key %h [%s] -> entry %h cnt %0d unlocked %0d err %0d lockout %0d",
               k, tag, entry_val, digit_cnt, unlocked, err, lockout);
  endtask

  task automatic press(input logic [3:0] k, input string tag, input logic [15:0] e_entry,
                       input logic [3:0] e_cnt, input logic e_u, input logic e_e, input logic e_l);
    tick(1'b1, k, tag, e_entry, e_cnt, e_u, e_e, e_l);
  endtask

  task automatic idle(input int n, input string tag, input logic [15:0] e_entry,
                      input logic [3:0] e_cnt, input logic e_u, input logic e_e, input logic e_l);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, tag, e_entry, e_cnt, e_u, e_e, e_l);
  endtask

  // Type four digits; entry grows as right-aligned BCD.
  task automatic enter_digits(input logic [15:0] code, input logic u, input string tag);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = code[15-4*i -: 4];
      press(d, tag, 16'(code >> (4 * (3 - i))), 4'(i + 1), u, 1'b0, 1'b0);
    end
  endtask

  task automatic unlock_and_expire(input string tag);
    enter_digits(16'h1234, 1'b0, tag);
    press(4'hA, tag, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(19, tag, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1, tag, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wrong_and_wait(input logic [15:0] code, input string tag);
    enter_digits(code, 1'b0, tag);
    press(4'hA, tag, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(4, tag, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(1, tag, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    #2;
    push_exp("reset", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    compare_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: correct code, unlocked for exactly 20 cycles
    unlock_and_expire("t1");

    // 2: wrong code -> err for 5 cycles, then correct code unlocks
    wrong_and_wait(16'h1235, "t2_wrong");
    unlock_and_expire("t2_ok");

    // 3: three wrong codes -> lockout for 40 cycles, keys ignored inside
    wrong_and_wait(16'h9999, "t3_w1");
    wrong_and_wait(16'h9999, "t3_w2");
    enter_digits(16'h9999, 1'b0, "t3_w3");
    press(4'hA, "t3_lock", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    press(4'h1, "t3_ign", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    press(4'h2, "t3_ign", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    press(4'h3, "t3_ign", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    press(4'h4, "t3_ign", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    press(4'hA, "t3_ign", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(34, "t3_lock", 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(1, "t3_end", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    unlock_and_expire("t3_after");

    // 4: saturation, ignored D, clear, short entry
    enter_digits(16'h1234, 1'b0, "t4");
    press(4'h5, "t4_sat", 16'h1234, 4'd4, 1'b0, 1'b0, 1'b0);
    press(4'hD, "t4_d", 16'h1234, 4'd4, 1'b0, 1'b0, 1'b0);
    press(4'hC, "t4_clr", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'h1, "t4_short", 16'h0001, 4'd1, 1'b0, 1'b0, 1'b0);
    press(4'h2, "t4_short", 16'h0012, 4'd2, 1'b0, 1'b0, 1'b0);
    press(4'hA, "t4_short", 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(4, "t4_err", 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(1, "t4_end", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

    // 5: early re-lock with C, then key on the expiry cycle is dropped
    enter_digits(16'h1234, 1'b0, "t5a");
    press(4'hA, "t5a", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(2, "t5a", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'hC, "t5a_c", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    enter_digits(16'h1234, 1'b0, "t5b");
    press(4'hA, "t5b", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(19, "t5b", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'h7, "t5b_drop", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'h1, "t5b_next", 16'h0001, 4'd1, 1'b0, 1'b0, 1'b0);
    press(4'hC, "t5b_clr", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef KEYPAD_CODE_CHANGE_EN
    // 6: change code to 5678, old code fails, new code works, reset restores
    enter_digits(16'h1234, 1'b0, "t6");
    press(4'hA, "t6", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'hB, "t6_new", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    enter_digits(16'h5678, 1'b1, "t6_new");
    press(4'hA, "t6_save", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    wrong_and_wait(16'h1234, "t6_old");
    enter_digits(16'h5678, 1'b0, "t6_newok");
    press(4'hA, "t6_newok", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3, "t6_newok", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    push_exp("t6_rst", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    compare_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    unlock_and_expire("t6_init");
`else
    // 6: without code change, B is ignored while unlocked
    enter_digits(16'h1234, 1'b0, "t6");
    press(4'hA, "t6", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'hB, "t6_b", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'h5, "t6_dig", 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'hC, "t6_c", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'h5, "t6_after", 16'h0005, 4'd1, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
